// File: rtl/lu_serial_sequencer_pkg.sv
// Shared definitions for the bit-serial logic-unit sequencer: op encodings,
// FSM state encoding and the bit-index counter width helper.
package lu_serial_sequencer_pkg;

  localparam logic LU_OP_AND  = 1'b0;
  localparam logic LU_OP_NAND = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lu_state_e;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int lu_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lu_serial_sequencer_shift_reg.sv
// N-bit right shift register with serial-in at the MSB.
// Priority: reset, clear, parallel load, shift.
module lu_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         ser_in,
  output logic [N-1:0] q
);

  logic [N-1:0] shifted;

  // Next value on a shift: serial bit enters at the MSB, LSB falls off.
  generate
    if (N == 1) begin : g_one
      assign shifted = ser_in;
    end else begin : g_multi
      assign shifted = {ser_in, q[N-1:1]};
    end
  endgenerate

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/lu_serial_sequencer.sv
// Bit-serial driver/collector for the 1-bit AND/NAND logic unit.
// Feeds one operand bit pair per cycle (LSB first) and collects lu_s into result.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for start; LU pins driven low
//   ST_RUN  | presenting bit cnt to the LU, capturing lu_s each edge
//   ST_DONE | result valid, done high for this single cycle
module lu_serial_sequencer
  import lu_serial_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         lu_s,
  output logic         lu_a,
  output logic         lu_b,
  output logic         lu_sel,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CNT_W = lu_cnt_w(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  lu_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  logic [N-1:0]     a_sh;
  logic [N-1:0]     b_sh;

  logic state_ok;
  logic in_run;
  logic accept;
  logic sh_clr;
  logic res_clr;
  logic unused_sh_bits;

  assign state_ok = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
  assign in_run   = (state == ST_RUN);
  assign accept   = (state == ST_IDLE) && start;
  // An illegal state encoding wipes the datapath so IDLE resumes from reset values.
  assign sh_clr   = !state_ok;
  assign res_clr  = accept || !state_ok;

  // Only the LSB of each operand register reaches the LU; upper bits are the shift pipeline.
  assign unused_sh_bits = ^{a_sh, b_sh};

  // Sequencing FSM and bit-index counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= LU_OP_AND;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            op_r  <= op;
          end
        end
        ST_RUN: begin
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          op_r  <= LU_OP_AND;
        end
      endcase
    end
  end

  lu_shift_reg #(.N(N)) u_a_sh (
    .clk      (clk),
    .reset    (reset),
    .clr      (sh_clr),
    .load     (accept),
    .load_val (a),
    .shift    (in_run),
    .ser_in   (1'b0),
    .q        (a_sh)
  );

  lu_shift_reg #(.N(N)) u_b_sh (
    .clk      (clk),
    .reset    (reset),
    .clr      (sh_clr),
    .load     (accept),
    .load_val (b),
    .shift    (in_run),
    .ser_in   (1'b0),
    .q        (b_sh)
  );

  lu_shift_reg #(.N(N)) u_result (
    .clk      (clk),
    .reset    (reset),
    .clr      (res_clr),
    .load     (1'b0),
    .load_val ({N{1'b0}}),
    .shift    (in_run),
    .ser_in   (lu_s),
    .q        (result)
  );

  // LU pins and handshake are decoded from registers only; lu_s never reaches an output.
  always_comb begin
    lu_a   = in_run & a_sh[0];
    lu_b   = in_run & b_sh[0];
    lu_sel = in_run & op_r;
    busy   = (state == ST_RUN) || (state == ST_DONE);
    done   = (state == ST_DONE);
  end

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Scoreboard bench for lu_serial_sequencer with N=4 and a behavioural LU.
module tb_lu_serial_sequencer;
  import lu_serial_sequencer_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         lu_s;
  logic         lu_a;
  logic         lu_b;
  logic         lu_sel;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int n_total = 0;
  int n_pass  = 0;

  logic [2:0]   pair_q[$];
  logic [N-1:0] res_q[$];
  int           busy_q[$];

  logic mon_en    = 1'b0;
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   busy_len  = 0;

  lu_serial_sequencer #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .lu_s   (lu_s),
    .lu_a   (lu_a),
    .lu_b   (lu_b),
    .lu_sel (lu_sel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  assign lu_s = lu_sel ? ~(lu_a & lu_b) : (lu_a & lu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [N-1:0] a_v, input logic [N-1:0] b_v, input logic op_v,
                         input logic [N-1:0] exp_res);
    for (int i = 0; i < N; i++) pair_q.push_back({op_v, a_v[i], b_v[i]});
    res_q.push_back(exp_res);
    busy_q.push_back(N + 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 20);
    if (!done) begin
      n_total++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a_v, input logic [N-1:0] b_v, input logic op_v);
    int c;
    a = a_v; b = b_v; op = op_v; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    check("latency", 32'(c), 32'(N));
    tick();
  endtask

  // Monitor: compares LU pins, results and busy length against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !done) begin
        if (pair_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_run: lu pins %0h with nothing expected", {lu_sel, lu_a, lu_b});
        end else begin
          check("lu_pins", 32'({lu_sel, lu_a, lu_b}), 32'(pair_q.pop_front()));
        end
      end else begin
        check("lu_pins_quiet", 32'({lu_sel, lu_a, lu_b}), 32'd0);
      end
      if (done) begin
        check("done_width", 32'(done_prev), 32'd0);
        if (res_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: result %0h with nothing expected", result);
        end else begin
          check("result", 32'(result), 32'(res_q.pop_front()));
        end
      end
      if (busy) busy_len++;
      if (!busy && busy_prev) begin
        if (busy_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_busy: length %0d with nothing expected", busy_len);
        end else begin
          check("busy_len", 32'(busy_len), 32'(busy_q.pop_front()));
        end
        busy_len = 0;
      end
      done_prev = done;
      busy_prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_lu_pins", 32'({lu_sel, lu_a, lu_b}), 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    tick();

    // AND then NAND on the same operands
    push_op(4'b1100, 4'b1010, LU_OP_AND, 4'b1000);
    run_op(4'b1100, 4'b1010, LU_OP_AND);
    push_op(4'b1100, 4'b1010, LU_OP_NAND, 4'b0111);
    run_op(4'b1100, 4'b1010, LU_OP_NAND);

    // start re-pulsed during RUN must be ignored
    push_op(4'b1111, 4'b1111, LU_OP_AND, 4'b1111);
    a = 4'b1111; b = 4'b1111; op = LU_OP_AND; start = 1'b1;
    tick();
    a = 4'b0000; op = LU_OP_NAND; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done(c);
    check("latency_ignored_start", 32'(c + 2), 32'(N));
    tick();
    check("result_hold", 32'(result), 32'b1111);
    check("idle_busy", 32'(busy), 32'd0);
    tick();

    // reset during the second RUN cycle aborts without done
    pair_q.push_back({LU_OP_AND, 1'b0, 1'b0});
    pair_q.push_back({LU_OP_AND, 1'b0, 1'b1});
    busy_q.push_back(2);
    a = 4'b1100; b = 4'b1010; op = LU_OP_AND; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    reset = 1'b0;
    tick();
    push_op(4'b1100, 4'b1010, LU_OP_AND, 4'b1000);
    run_op(4'b1100, 4'b1010, LU_OP_AND);

    // start held high: back-to-back ops every N+2 cycles
    for (int k = 0; k < 3; k++) push_op(4'b0101, 4'b0011, LU_OP_NAND, 4'b1110);
    a = 4'b0101; b = 4'b0011; op = LU_OP_NAND; start = 1'b1;
    tick();
    wait_done(c);
    check("held_first_latency", 32'(c), 32'(N));
    wait_done(c);
    check("held_period", 32'(c), 32'(N + 2));
    wait_done(c);
    check("held_period", 32'(c), 32'(N + 2));
    start = 1'b0;
    tick();
    tick();
    tick();

    check("pairs_drained", 32'(pair_q.size()), 32'd0);
    check("results_drained", 32'(res_q.size()), 32'd0);
    check("busy_drained", 32'(busy_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
